// File: rtl/rdiv_pkg.sv
// Shared types and sizing helpers for the rdiv sequential restoring divider.
package rdiv_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rdiv_subtr.sv
// Ripple-borrow subtractor (x + ~y + 1) built from full-adder cells; used for
// the divider's trial subtraction.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module subtr #(
  parameter int N = 5
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] diff,
  output logic         borrow
);
  logic [N-1:0] y_inv;
  logic [N-1:0] carry;

  assign y_inv    = ~y;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N - 1; i++) begin : g_fa
    full_adder u_fa (
      .x   (x[i]),
      .y   (y_inv[i]),
      .cin (carry[i]),
      .s   (diff[i]),
      .cout(carry[i+1])
    );
  end

  // The top stage only needs its sum bit; its carry-out has no consumer.
  assign diff[N-1] = x[N-1] ^ y_inv[N-1] ^ carry[N-1];
  assign borrow    = diff[N-1];

endmodule

// File: rtl/rdiv.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done
// handshake. Define RDIV_DIVZERO_EN to short-circuit b=0 and raise dz.
module rdiv
  import rdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             accept;
  logic             last;

  // A restored or accepted remainder is always below the divisor, so its
  // top bit is zero and R is kept WIDTH bits wide; the shift restores WIDTH+1.
  assign shifted = {rem, quo[WIDTH-1]};

  subtr #(.N(WIDTH + 1)) u_subtr (
    .x     (shifted),
    .y     ({1'b0, div}),
    .diff  (trial),
    .borrow(borrow)
  );

  assign quo_nxt = {quo[WIDTH-2:0], ~borrow};
  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

  assign accept = start && (state != CALC);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

`ifdef RDIV_DIVZERO_EN
  logic zero_div;
  assign zero_div = (b == '0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef RDIV_DIVZERO_EN
          state_nxt = zero_div ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, so results read as zero after
  // reset rather than stale or unknown values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo <= '0;
      div <= '0;
      rem <= '0;
      cnt <= '0;
      q   <= '0;
      r   <= '0;
    end else if (accept) begin
      quo <= a;
      div <= b;
      rem <= '0;
      cnt <= '0;
`ifdef RDIV_DIVZERO_EN
      if (zero_div) begin
        q <= '1;
        r <= a;
      end
`endif
    end else if (state == CALC) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        q <= quo_nxt;
        r <= rem_nxt;
      end
    end
  end

`ifdef RDIV_DIVZERO_EN
  logic dz_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       dz_r <= 1'b0;
    else if (accept && zero_div)     dz_r <= 1'b1;
    else if (state == CALC && last)  dz_r <= 1'b0;
  end

  assign dz = dz_r;
`else
  assign dz = 1'b0;
`endif

endmodule
